// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single read/write port of the unified program/data RAM between
// instruction fetch (IF) and the memory-access stage (D) with a req/ack
// handshake. D has priority; a saturating starvation counter forces an IF grant
// after MAX_DATA_BURST consecutive D grants taken while IF was waiting.
// The granted port drives the RAM combinationally in its grant cycle, and
// registered copies hold the RAM inputs stable for the rest of the access.
// A store commits in its grant cycle, so its ack arrives the following cycle
// with the arbiter already back in IDLE. A load or fetch acks RD_LAT+1 cycles
// after its grant.

module mem_port_arbiter #(
  parameter int unsigned RD_LAT         = 1,
  parameter int unsigned MAX_DATA_BURST = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteen,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [29:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_byteen,
  output logic        ram_wren,
  input  logic [31:0] ram_q,
  output logic        busy,
  output logic        gnt_d
);

  localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int unsigned STV_W = (MAX_DATA_BURST > 0) ? $clog2(MAX_DATA_BURST + 1) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LAT - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(MAX_DATA_BURST);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [STV_W-1:0]   starve_q, starve_d;
  logic               if_ack_q, if_ack_d;
  logic               d_ack_q, d_ack_d;
  logic [31:0]        if_rdata_q, if_rdata_d;
  logic [31:0]        d_rdata_q, d_rdata_d;
  logic [29:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         byteen_q, byteen_d;
  logic               gnt_d_q, gnt_d_d;

  logic               d_elig;
  logic               if_elig;
  logic               grant_d;
  logic               grant_if;

  // Byte-offset address bits are dropped; word addressing only.
  logic               unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

  // Eligibility and grant decision; a request seen during its own ack is a leftover.
  always_comb begin
    d_elig   = d_req & ~d_ack_q;
    if_elig  = if_req & ~if_ack_q;
    grant_d  = 1'b0;
    grant_if = 1'b0;
    if (state_q == ST_IDLE) begin
      if (d_elig && ((starve_q < STV_MAX) || !if_elig)) begin
        grant_d = 1'b1;
      end else if (if_elig) begin
        grant_if = 1'b1;
      end else begin
        grant_d  = 1'b0;
        grant_if = 1'b0;
      end
    end else begin
      grant_d  = 1'b0;
      grant_if = 1'b0;
    end
  end

  // RAM port steering: granted port drives directly in its grant cycle, copies hold otherwise.
  always_comb begin
    ram_addr   = addr_q;
    ram_wdata  = wdata_q;
    ram_byteen = byteen_q;
    ram_wren   = 1'b0;
    if (grant_d) begin
      ram_addr  = d_addr[31:2];
      ram_wdata = d_wdata;
      if (d_we) begin
        ram_byteen = d_byteen;
        ram_wren   = 1'b1;
      end else begin
        ram_byteen = 4'b1111;
        ram_wren   = 1'b0;
      end
    end else if (grant_if) begin
      ram_addr   = if_addr[31:2];
      ram_byteen = 4'b1111;
      ram_wren   = 1'b0;
    end else begin
      ram_wren = 1'b0;
    end
  end

  // Next-state, starvation counter, latency countdown, read capture and ack pulses.
  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    starve_d   = starve_q;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    gnt_d_d    = gnt_d_q;
    addr_d     = ram_addr;
    wdata_d    = ram_wdata;
    byteen_d   = ram_byteen;
    case (state_q)
      ST_IDLE: begin
        if (grant_d) begin
          gnt_d_d = 1'b1;
          if (if_elig) begin
            if (starve_q != STV_MAX) begin
              starve_d = starve_q + STV_W'(1);
            end else begin
              starve_d = starve_q;
            end
          end else begin
            starve_d = '0;
          end
          if (d_we) begin
            // Store is written this cycle; ack next cycle while back in IDLE.
            d_ack_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            lat_d   = LAT_INIT;
            state_d = ST_READ;
          end
        end else if (grant_if) begin
          gnt_d_d  = 1'b0;
          starve_d = '0;
          lat_d    = LAT_INIT;
          state_d  = ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (lat_q != LAT_W'(0)) begin
          lat_d = lat_q - LAT_W'(1);
        end else begin
          if (gnt_d_q) begin
            d_rdata_d = ram_q;
            d_ack_d   = 1'b1;
          end else begin
            if_rdata_d = ram_q;
            if_ack_d   = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        // Stores complete in their grant cycle; this state only recovers to IDLE.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      lat_q      <= '0;
      starve_q   <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      if_rdata_q <= 32'h0000_0000;
      d_rdata_q  <= 32'h0000_0000;
      addr_q     <= 30'h0000_0000;
      wdata_q    <= 32'h0000_0000;
      byteen_q   <= 4'b1111;
      gnt_d_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      starve_q   <= starve_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      byteen_q   <= byteen_d;
      gnt_d_q    <= gnt_d_d;
    end
  end

  assign if_ack   = if_ack_q;
  assign d_ack    = d_ack_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign busy     = (state_q != ST_IDLE);
  assign gnt_d    = gnt_d_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Two instances share the inputs:
// u1 (RD_LAT=1, MAX_DATA_BURST=2) and u3 (RD_LAT=3, MAX_DATA_BURST=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.

module tb_mem_port_arbiter;

  logic        clk;
  logic        reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_byteen;
  logic [31:0] ram_q;

  logic        if_ack_1, d_ack_1, ram_wren_1, busy_1, gnt_d_1;
  logic [31:0] if_rdata_1, d_rdata_1, ram_wdata_1;
  logic [29:0] ram_addr_1;
  logic [3:0]  ram_byteen_1;

  logic        if_ack_3, d_ack_3, ram_wren_3, busy_3, gnt_d_3;
  logic [31:0] if_rdata_3, d_rdata_3, ram_wdata_3;
  logic [29:0] ram_addr_3;
  logic [3:0]  ram_byteen_3;

  int n_pass;
  int n_total;

  mem_port_arbiter #(.RD_LAT(1), .MAX_DATA_BURST(2)) u1 (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack_1), .if_rdata(if_rdata_1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_byteen(d_byteen),
    .d_ack(d_ack_1), .d_rdata(d_rdata_1),
    .ram_addr(ram_addr_1), .ram_wdata(ram_wdata_1), .ram_byteen(ram_byteen_1),
    .ram_wren(ram_wren_1), .ram_q(ram_q), .busy(busy_1), .gnt_d(gnt_d_1)
  );

  mem_port_arbiter #(.RD_LAT(3), .MAX_DATA_BURST(4)) u3 (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack_3), .if_rdata(if_rdata_3),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_byteen(d_byteen),
    .d_ack(d_ack_3), .d_rdata(d_rdata_3),
    .ram_addr(ram_addr_3), .ram_wdata(ram_wdata_3), .ram_byteen(ram_byteen_3),
    .ram_wren(ram_wren_3), .ram_q(ram_q), .busy(busy_3), .gnt_d(gnt_d_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: sim time %0t exceeded limit", $time);
    $fatal(1, "time limit");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req   = 1'b0;
    if_addr  = 32'h0;
    d_req    = 1'b0;
    d_we     = 1'b0;
    d_addr   = 32'h0;
    d_wdata  = 32'h0;
    d_byteen = 4'b0000;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_inputs();
    ram_q = 32'h0;
    @(negedge clk);
    n_total++;
    if ({busy_1, if_ack_1, d_ack_1, ram_wren_1, gnt_d_1} !== 5'b00000)
      $display("FAIL reset_ctl: got %b want 00000", {busy_1, if_ack_1, d_ack_1, ram_wren_1, gnt_d_1});
    else n_pass++;
    n_total++;
    if (ram_byteen_1 !== 4'b1111) $display("FAIL reset_byteen: got %b want 1111", ram_byteen_1);
    else n_pass++;
    n_total++;
    if ({ram_addr_1, ram_wdata_1, if_rdata_1, d_rdata_1} !== 126'h0)
      $display("FAIL reset_data: addr %h wdata %h ifr %h dr %h want all 0",
               ram_addr_1, ram_wdata_1, if_rdata_1, d_rdata_1);
    else n_pass++;
    n_total++;
    if ({busy_3, ram_byteen_3} !== 5'b01111)
      $display("FAIL reset_u3: got %b want 01111", {busy_3, ram_byteen_3});
    else n_pass++;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_fetch();
    do_reset();
    if_req  = 1'b1;
    if_addr = 32'h0000_0040;
    ram_q   = 32'hDEAD_BEEF;
    @(negedge clk);
    n_total++;
    if ({ram_addr_1, ram_wren_1, ram_byteen_1} !== {30'h10, 1'b0, 4'b1111})
      $display("FAIL fetch_drive: addr %h wren %b be %b want 10 0 1111", ram_addr_1, ram_wren_1, ram_byteen_1);
    else n_pass++;
    next_cycle();
    @(negedge clk);
    n_total++;
    if ({if_ack_1, busy_1, ram_addr_1} !== {1'b0, 1'b1, 30'h10})
      $display("FAIL fetch_t1: ack %b busy %b addr %h want 0 1 10", if_ack_1, busy_1, ram_addr_1);
    else n_pass++;
    next_cycle();
    if_req = 1'b0;
    ram_q  = 32'h1234_5678;
    @(negedge clk);
    n_total++;
    if ({if_ack_1, if_rdata_1, busy_1} !== {1'b1, 32'hDEAD_BEEF, 1'b0})
      $display("FAIL fetch_ack: ack %b rdata %h busy %b want 1 deadbeef 0", if_ack_1, if_rdata_1, busy_1);
    else n_pass++;
    next_cycle();
    @(negedge clk);
    n_total++;
    if ({if_ack_1, if_rdata_1} !== {1'b0, 32'hDEAD_BEEF})
      $display("FAIL fetch_hold: ack %b rdata %h want 0 deadbeef", if_ack_1, if_rdata_1);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_store_priority();
    do_reset();
    d_req    = 1'b1;
    d_we     = 1'b1;
    d_addr   = 32'h0000_0103;
    d_byteen = 4'b1000;
    d_wdata  = 32'hAA00_0000;
    if_req   = 1'b1;
    if_addr  = 32'h0000_0080;
    ram_q    = 32'h0BAD_F00D;
    @(negedge clk);
    n_total++;
    if ({ram_wren_1, ram_addr_1, ram_byteen_1, ram_wdata_1} !== {1'b1, 30'h40, 4'b1000, 32'hAA00_0000})
      $display("FAIL store_drive: wren %b addr %h be %b wdata %h want 1 40 1000 aa000000",
               ram_wren_1, ram_addr_1, ram_byteen_1, ram_wdata_1);
    else n_pass++;
    next_cycle();
    @(negedge clk);
    n_total++;
    if ({d_ack_1, ram_wren_1, ram_addr_1, busy_1, gnt_d_1} !== {1'b1, 1'b0, 30'h20, 1'b0, 1'b1})
      $display("FAIL store_t1: dack %b wren %b addr %h busy %b gntd %b want 1 0 20 0 1",
               d_ack_1, ram_wren_1, ram_addr_1, busy_1, gnt_d_1);
    else n_pass++;
    next_cycle();
    d_req = 1'b0;
    @(negedge clk);
    n_total++;
    if ({d_ack_1, ram_wren_1, busy_1, gnt_d_1, if_ack_1} !== 5'b00100)
      $display("FAIL store_t2: dack %b wren %b busy %b gntd %b iack %b want 0 0 1 0 0",
               d_ack_1, ram_wren_1, busy_1, gnt_d_1, if_ack_1);
    else n_pass++;
    next_cycle();
    if_req = 1'b0;
    @(negedge clk);
    n_total++;
    if ({if_ack_1, if_rdata_1, d_ack_1} !== {1'b1, 32'h0BAD_F00D, 1'b0})
      $display("FAIL store_if_ack: iack %b rdata %h dack %b want 1 0badf00d 0", if_ack_1, if_rdata_1, d_ack_1);
    else n_pass++;
    next_cycle();
  endtask

  // Both ports raise together each round; losing requester withdraws until the
  // winner completes. With a burst limit of 2 the order is D, D, IF, D.
  task automatic test_starvation();
    logic exp_d [4];
    logic [29:0] exp_addr;
    do_reset();
    exp_d[0] = 1'b1; exp_d[1] = 1'b1; exp_d[2] = 1'b0; exp_d[3] = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h0000_0200;
    if_addr = 32'h0000_0300;
    for (int r = 0; r < 4; r++) begin
      d_req  = 1'b1;
      if_req = 1'b1;
      exp_addr = exp_d[r] ? 30'h80 : 30'hC0;
      @(negedge clk);
      n_total++;
      if (ram_addr_1 !== exp_addr)
        $display("FAIL starve_grant%0d: addr %h want %h", r, ram_addr_1, exp_addr);
      else n_pass++;
      next_cycle();
      if (exp_d[r]) if_req = 1'b0; else d_req = 1'b0;
      @(negedge clk);
      n_total++;
      if ({gnt_d_1, busy_1} !== {exp_d[r], 1'b1})
        $display("FAIL starve_gnt%0d: gntd %b busy %b want %b 1", r, gnt_d_1, busy_1, exp_d[r]);
      else n_pass++;
      next_cycle();
      d_req  = 1'b0;
      if_req = 1'b0;
      @(negedge clk);
      n_total++;
      if ({d_ack_1, if_ack_1} !== {exp_d[r], ~exp_d[r]})
        $display("FAIL starve_ack%0d: dack %b iack %b want %b %b", r, d_ack_1, if_ack_1, exp_d[r], ~exp_d[r]);
      else n_pass++;
      next_cycle();
    end
  endtask

  // Both requests held: neither port can be re-granted in its own ack cycle,
  // so the grants alternate D, IF, D, ... with one-cycle acks.
  task automatic test_alternate();
    logic exp_dack, exp_iack, exp_busy;
    do_reset();
    d_we    = 1'b0;
    d_addr  = 32'h0000_0200;
    if_addr = 32'h0000_0300;
    d_req   = 1'b1;
    if_req  = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      exp_dack = (c >= 2) && ((c - 2) % 4 == 0);
      exp_iack = (c >= 4) && (c % 4 == 0);
      exp_busy = (c % 2 == 1);
      @(negedge clk);
      n_total++;
      if ({d_ack_1, if_ack_1, busy_1} !== {exp_dack, exp_iack, exp_busy})
        $display("FAIL alt_c%0d: dack %b iack %b busy %b want %b %b %b",
                 c, d_ack_1, if_ack_1, busy_1, exp_dack, exp_iack, exp_busy);
      else n_pass++;
      next_cycle();
    end
    clear_inputs();
    repeat (4) next_cycle();
  endtask

  task automatic test_back_to_back();
    logic exp_ack, exp_busy;
    do_reset();
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h0000_0010;
    ram_q  = 32'hCAFE_F00D;
    for (int c = 0; c <= 10; c++) begin
      if (c == 6) d_req = 1'b0;
      exp_ack  = (c == 4) || (c == 9);
      exp_busy = (c >= 1 && c <= 3) || (c >= 6 && c <= 8);
      @(negedge clk);
      n_total++;
      if ({d_ack_3, busy_3} !== {exp_ack, exp_busy})
        $display("FAIL b2b_c%0d: dack %b busy %b want %b %b", c, d_ack_3, busy_3, exp_ack, exp_busy);
      else n_pass++;
      if (c == 0 || c == 5) begin
        n_total++;
        if (ram_addr_3 !== 30'h4) $display("FAIL b2b_addr%0d: addr %h want 4", c, ram_addr_3);
        else n_pass++;
      end
      if (c == 4) begin
        n_total++;
        if (d_rdata_3 !== 32'hCAFE_F00D) $display("FAIL b2b_rdata: got %h want cafef00d", d_rdata_3);
        else n_pass++;
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    if_req  = 1'b1;
    if_addr = 32'h0000_0044;
    ram_q   = 32'h5555_AAAA;
    @(negedge clk);
    n_total++;
    if (ram_addr_3 !== 30'h11) $display("FAIL rmid_grant: addr %h want 11", ram_addr_3);
    else n_pass++;
    next_cycle();
    if_req = 1'b0;
    @(negedge clk);
    n_total++;
    if (busy_3 !== 1'b1) $display("FAIL rmid_busy: got %b want 1", busy_3);
    else n_pass++;
    next_cycle();
    reset_n = 1'b0;
    #1;
    n_total++;
    if ({busy_3, if_ack_3, gnt_d_3, ram_wren_3, ram_byteen_3, ram_addr_3, if_rdata_3}
        !== {4'b0000, 4'b1111, 30'h0, 32'h0})
      $display("FAIL rmid_async: busy %b ack %b gnt %b wren %b be %b addr %h rdata %h want reset values",
               busy_3, if_ack_3, gnt_d_3, ram_wren_3, ram_byteen_3, ram_addr_3, if_rdata_3);
    else n_pass++;
    next_cycle();
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_total++;
      if ({if_ack_3, busy_3, if_rdata_3} !== {2'b00, 32'h0})
        $display("FAIL rmid_after%0d: ack %b busy %b rdata %h want 0 0 0", c, if_ack_3, busy_3, if_rdata_3);
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_idle();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_total++;
      if ({busy_1, ram_wren_1, if_ack_1, d_ack_1, busy_3, ram_wren_3, if_ack_3, d_ack_3} !== 8'h00)
        $display("FAIL idle_c%0d: got %b want 00000000", c,
                 {busy_1, ram_wren_1, if_ack_1, d_ack_1, busy_3, ram_wren_3, if_ack_3, d_ack_3});
      else n_pass++;
      next_cycle();
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset_n = 1'b0;
    ram_q   = 32'h0;
    clear_inputs();
    test_reset();
    test_fetch();
    test_store_priority();
    test_starvation();
    test_alternate();
    test_back_to_back();
    test_reset_mid();
    test_idle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
